// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Runs request-to-send, shifts {parity, din} LSB first on device clock
// falls, checks the device ACK and reports done or error.
// Ports:
//   clk, reset           system clock, async active-high reset
//   ps2c_in, ps2d_in     sampled PS/2 clock / data pads
//   wr_ps2, din          one-cycle send request and command byte
//   ps2c_oe, ps2d_oe     1 = pull the line low, 0 = release
//   tx_idle              high in IDLE (feeds the receiver's rx_en)
//   tx_done_tick         one-cycle pulse on ACK
//   tx_err_tick          one-cycle pulse on NACK or timeout
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);

    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                          INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW0  = $clog2(MAXC + 1);
    localparam int CW   = (CW0 < 4) ? 4 : CW0;

    localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] RTSD_LAST = CW'(15);

    typedef enum logic [2:0] {
        IDLE, RTS, RTS_D, START, DATA, STOP, ACK, WAIT_REL
    } state_t;

    state_t        state;
    logic [7:0]    filt;
    logic          fclk;
    logic          fclk_next;
    logic          fall;
    logic [8:0]    frame;
    logic [3:0]    bitcnt;
    logic [CW-1:0] cnt;
    logic          ack_ok;
    logic          watch;
    logic          rel;
    logic          timeout;

    // Glitch filter: the clock only changes after 8 identical samples.
    always_comb begin
        fclk_next = fclk;
        if (filt == 8'h00)
            fclk_next = 1'b0;
        else if (filt == 8'hFF)
            fclk_next = 1'b1;
        fall = fclk & ~fclk_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt <= 8'hFF;
            fclk <= 1'b1;
        end else begin
            filt <= {ps2c_in, filt[7:1]};
            fclk <= fclk_next;
        end
    end

    // Our own clock pull-down during RTS also makes the filtered clock
    // fall, so falls only matter once the device owns the clock.
    always_comb begin
        watch = (state == START) || (state == DATA) ||
                (state == STOP)  || (state == ACK)  ||
                (state == WAIT_REL);
        rel     = (state == WAIT_REL) && fclk && ps2d_in;
        timeout = watch && !fall && !rel && (cnt == TO_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            frame        <= '0;
            bitcnt       <= '0;
            cnt          <= '0;
            ack_ok       <= 1'b0;
            ps2c_oe      <= 1'b0;
            ps2d_oe      <= 1'b0;
            tx_idle      <= 1'b1;
            tx_done_tick <= 1'b0;
            tx_err_tick  <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            tx_err_tick  <= 1'b0;
            cnt <= (watch && fall) ? '0 : cnt + CW'(1);
            if (timeout) begin
                state       <= IDLE;
                cnt         <= '0;
                ps2c_oe     <= 1'b0;
                ps2d_oe     <= 1'b0;
                tx_idle     <= 1'b1;
                tx_err_tick <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (wr_ps2) begin
                            state   <= RTS;
                            frame   <= {~^din, din};
                            ps2c_oe <= 1'b1;
                            tx_idle <= 1'b0;
                        end
                    end
                    RTS: begin
                        if (cnt == INH_LAST) begin
                            state   <= RTS_D;
                            cnt     <= '0;
                            ps2d_oe <= 1'b1;
                        end
                    end
                    RTS_D: begin
                        if (cnt == RTSD_LAST) begin
                            state   <= START;
                            cnt     <= '0;
                            ps2c_oe <= 1'b0;
                        end
                    end
                    START: begin
                        if (fall) begin
                            state   <= DATA;
                            bitcnt  <= '0;
                            ps2d_oe <= ~frame[0];
                        end
                    end
                    DATA: begin
                        if (fall) begin
                            if (bitcnt == 4'd8) begin
                                state   <= STOP;
                                ps2d_oe <= 1'b0;
                            end else begin
                                bitcnt  <= bitcnt + 4'd1;
                                frame   <= {1'b0, frame[8:1]};
                                ps2d_oe <= ~frame[1];
                            end
                        end
                    end
                    STOP: begin
                        if (fall)
                            state <= ACK;
                    end
                    // Entered on the 11th fall: the device holds the
                    // ACK level on data for the whole low phase.
                    ACK: begin
                        ack_ok <= ~ps2d_in;
                        state  <= WAIT_REL;
                        cnt    <= '0;
                    end
                    WAIT_REL: begin
                        if (rel) begin
                            state        <= IDLE;
                            cnt          <= '0;
                            tx_idle      <= 1'b1;
                            tx_done_tick <= ack_ok;
                            tx_err_tick  <= ~ack_ok;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with a
// behavioural PS/2 keyboard model on the open-drain pads.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TO  = 500;
    localparam int H   = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_c = 1'b1;
    logic       dev_d = 1'b1;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err_tick;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int mon_bad = 0;

    assign ps2c_in = dev_c & ~ps2c_oe;
    assign ps2d_in = dev_d & ~ps2d_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ps2c_in(ps2c_in),
        .ps2d_in(ps2d_in),
        .wr_ps2(wr_ps2),
        .din(din),
        .ps2c_oe(ps2c_oe),
        .ps2d_oe(ps2d_oe),
        .tx_idle(tx_idle),
        .tx_done_tick(tx_done_tick),
        .tx_err_tick(tx_err_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!reset) begin
            if (tx_done_tick) done_cnt <= done_cnt + 1;
            if (tx_err_tick) err_cnt <= err_cnt + 1;
            if ((tx_done_tick || tx_err_tick) &&
                (!tx_idle || (tx_done_tick && tx_err_tick) ||
                 ps2c_oe || ps2d_oe))
                mon_bad <= mon_bad + 1;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    // Keyboard model: clocks nclk bits, samples data on rising edges.
    task automatic device(input bit ack, input int nclk,
                          input int wr_at, input int glitch_at,
                          input int rst_at, input bit lag_chk,
                          output logic [10:0] got, output bit aborted);
        int k;
        int lag;
        bit seen;
        got = '1;
        aborted = 0;
        seen = 0;
        lag = -1;
        for (k = 0; k < 100 && !(ps2c_oe == 0 && ps2d_oe == 1); k++)
            @(negedge clk);
        check("start_drive", int'({ps2c_oe, ps2d_oe}), 1);
        repeat (20) @(negedge clk);
        for (int i = 1; i <= nclk; i++) begin
            if (i == 1) got[0] = ps2d_in;
            if (i == 11) dev_d = ack ? 1'b0 : 1'b1;
            dev_c = 1'b0;
            last_fall_cyc = cyc;
            for (int j = 1; j <= H; j++) begin
                @(negedge clk);
                if (i == 1 && !seen && !ps2d_oe) begin
                    seen = 1;
                    lag = cyc - last_fall_cyc;
                end
                if (i == glitch_at && j == 10) dev_c = 1'b1;
                if (i == glitch_at && j == 13) dev_c = 1'b0;
            end
            if (i <= 10) got[i] = ps2d_in;
            dev_c = 1'b1;
            if (i == 11) dev_d = 1'b1;
            if (i == nclk) break;
            for (int j = 1; j <= H; j++) begin
                @(negedge clk);
                if (i == glitch_at && j == 10) dev_c = 1'b0;
                if (i == glitch_at && j == 13) dev_c = 1'b1;
                if (i == wr_at && j == 5) begin
                    din = 8'hAA;
                    wr_ps2 = 1'b1;
                end
                if (i == wr_at && j == 6) wr_ps2 = 1'b0;
                if (i == rst_at && j == 5) begin
                    check("pre_reset_d", int'(ps2d_oe), 1);
                    #2 reset = 1'b1;
                    #1;
                    check("async_rst_idle", int'(tx_idle), 1);
                    check("async_rst_oe", int'({ps2c_oe, ps2d_oe}), 0);
                    @(negedge clk);
                    reset = 1'b0;
                    aborted = 1;
                    return;
                end
            end
        end
        if (lag_chk) check("fall_lag", lag, 9);
    endtask

    task automatic send(input logic [7:0] b, input bit ack,
                        input int nclk, input int wr_at,
                        input int glitch_at, input int rst_at,
                        input bit lag_chk, output logic [10:0] got,
                        output int dd, output int de, output int tlat,
                        output bit aborted);
        int ch;
        int cd;
        int k;
        bit order_bad;
        dd = 0;
        de = 0;
        tlat = -1;
        din = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din = ~b;
        check("accept_c_oe", int'(ps2c_oe), 1);
        check("accept_idle", int'(tx_idle), 0);
        ch = 0;
        cd = 0;
        order_bad = 0;
        for (k = 0; k < 1000 && ps2c_oe; k++) begin
            ch++;
            if (ps2d_oe) cd++;
            else if (cd != 0) order_bad = 1;
            @(negedge clk);
        end
        check("rts_c_len", ch, INH + 16);
        check("rts_d_len", cd, 16);
        check("rts_order", int'(order_bad), 0);
        device(ack, nclk, wr_at, glitch_at, rst_at, lag_chk, got, aborted);
        if (aborted) return;
        for (k = 0; k < TO + 300 && !tx_idle; k++) begin
            @(negedge clk);
            if (tx_done_tick) dd++;
            if (tx_err_tick) begin
                de++;
                tlat = cyc - last_fall_cyc;
            end
        end
        check("idle_return", int'(tx_idle), 1);
        check("released", int'({ps2c_oe, ps2d_oe}), 0);
    endtask

    typedef struct {
        logic [7:0] din;
        bit         ack;
        bit         par;
        int         done;
        int         err;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [10:0] got;
        logic [10:0] expf;
        logic [7:0]  b;
        int dd;
        int de;
        int tl;
        int hi;
        int exp_done;
        int exp_err;
        bit ab;
        bit a;
        bit par;

        tbl[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
        tbl[1] = '{8'h00, 1'b1, 1'b1, 1, 0};
        tbl[2] = '{8'h01, 1'b1, 1'b0, 1, 0};
        tbl[3] = '{8'hFF, 1'b0, 1'b1, 0, 1};
        tbl[4] = '{8'hF4, 1'b1, 1'b0, 1, 0};
        exp_done = 0;
        exp_err = 0;

        repeat (3) @(negedge clk);
        check("rst_idle", int'(tx_idle), 1);
        check("rst_oe", int'({ps2c_oe, ps2d_oe}), 0);
        check("rst_ticks", int'({tx_done_tick, tx_err_tick}), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send(tbl[i].din, tbl[i].ack, 11, 0, 0, 0, i == 0,
                 got, dd, de, tl, ab);
            expf = {1'b1, tbl[i].par, tbl[i].din, 1'b0};
            check("tbl_frame", int'(got), int'(expf));
            check("tbl_parity", int'(got[9]), int'(tbl[i].par));
            check("tbl_done", dd, tbl[i].done);
            check("tbl_err", de, tbl[i].err);
            exp_done += tbl[i].done;
            exp_err += tbl[i].err;
        end

        for (int r = 0; r < 6; r++) begin
            b = 8'($urandom_range(0, 255));
            a = 1'($urandom_range(0, 1));
            par = ($countones(b) % 2) == 0;
            send(b, a, 11, 0, 0, 0, 0, got, dd, de, tl, ab);
            expf = {1'b1, par, b, 1'b0};
            check("rnd_frame", int'(got), int'(expf));
            check("rnd_done", dd, int'(a));
            check("rnd_err", de, int'(!a));
            exp_done += int'(a);
            exp_err += int'(!a);
        end

        send(8'hE6, 1'b1, 4, 0, 0, 0, 0, got, dd, de, tl, ab);
        check("to_bits", int'(got[4:1]), 6);
        check("to_done", dd, 0);
        check("to_err", de, 1);
        check("to_latency", tl, TO + 9);
        exp_err += 1;
        send(8'hF4, 1'b1, 11, 0, 0, 0, 0, got, dd, de, tl, ab);
        check("after_to_frame", int'(got), int'({2'b10, 8'hF4, 1'b0}));
        check("after_to_done", dd, 1);
        exp_done += 1;

        send(8'h55, 1'b1, 11, 3, 0, 0, 0, got, dd, de, tl, ab);
        check("busy_wr_frame", int'(got), int'({2'b11, 8'h55, 1'b0}));
        check("busy_wr_done", dd, 1);
        exp_done += 1;
        hi = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ps2c_oe || !tx_idle) hi++;
        end
        check("busy_wr_no_resend", hi, 0);

        send(8'hED, 1'b1, 11, 0, 0, 2, 0, got, dd, de, tl, ab);
        check("reset_aborted", int'(ab), 1);
        repeat (5) @(negedge clk);
        send(8'hED, 1'b1, 11, 0, 0, 0, 0, got, dd, de, tl, ab);
        check("post_rst_frame", int'(got), int'({2'b11, 8'hED, 1'b0}));
        check("post_rst_done", dd, 1);
        exp_done += 1;

        send(8'h3C, 1'b1, 11, 0, 4, 0, 0, got, dd, de, tl, ab);
        check("glitch_frame", int'(got), int'({2'b11, 8'h3C, 1'b0}));
        check("glitch_done", dd, 1);
        exp_done += 1;

        repeat (5) @(negedge clk);
        check("total_done", done_cnt, exp_done);
        check("total_err", err_cnt, exp_err);
        check("pulse_rules", mon_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the shared open-drain PS/2 clock and data lines. It runs the request-to-send sequence, shifts out start/data/parity/stop bits on device-generated clock edges, checks the device acknowledge bit, and reports success or failure. It sits beside the PS/2 receiver and keypress decoder; its `tx_idle` output drives the receiver's `rx_en`, so the receiver is disabled while a frame is being transmitted.

## Interface
- `INHIBIT_CYCLES`, default 6000: clk cycles the clock line is held low for request-to-send (≥100 µs; 120 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 1_000_000: maximum clk cycles to wait for any single device clock falling edge before aborting (20 ms at 50 MHz).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `ps2c_in` in 1: sampled PS/2 clock pad (asynchronous to clk).
- `ps2d_in` in 1: sampled PS/2 data pad.
- `wr_ps2` in 1: one-cycle request to send `din`; honoured only when `tx_idle`=1.
- `din` in 8: command byte, captured on the accepting cycle.
- `ps2c_oe` out 1: 1 = pull PS/2 clock low; 0 = release (high-Z at the top level).
- `ps2d_oe` out 1: 1 = pull PS/2 data low; 0 = release.
- `tx_idle` out 1: 1 when in IDLE; connects to the receiver's `rx_en`.
- `tx_done_tick` out 1: one-cycle pulse after the device ACKs (data low on the 11th clock).
- `tx_err_tick` out 1: one-cycle pulse on NACK or timeout.

## Operation
- Clock filter: 8-bit shift register on `ps2c_in`. The filtered clock becomes 0 when all 8 bits are 0 and 1 when all 8 bits are 1; otherwise it holds its value. `fall` = filtered clock transitions 1→0, a one-cycle pulse. Reset value of the filtered clock is 1.
- Frame register `{parity, din[7:0]}`, with odd parity: `parity` = ~^din. Shifted LSB first. A 4-bit bit counter tracks position.
- Cycle counter: wide enough for max(INHIBIT_CYCLES, TIMEOUT_CYCLES). It clears on every state entry and on every `fall`.
- State machine:
  - IDLE: `ps2c_oe`=0, `ps2d_oe`=0, `tx_idle`=1. On `wr_ps2` → RTS and latch the frame.
  - RTS: `ps2c_oe`=1, `ps2d_oe`=0 for INHIBIT_CYCLES cycles → RTS_D.
  - RTS_D: `ps2c_oe`=1, `ps2d_oe`=1 (start bit) for 16 cycles → START.
  - START: `ps2c_oe`=0, `ps2d_oe`=1. On `fall` → DATA, bit counter = 0, and present frame bit 0.
  - DATA: `ps2d_oe` = ~current frame bit. On each `fall`, advance to the next bit. After the `fall` that ends the parity bit (9th bit), go → STOP.
  - STOP: `ps2d_oe`=0 (data released, stop = 1). On `fall` → ACK.
  - ACK: lines released. On `fall`, sample `ps2d_in`: 0 → WAIT_REL with ack_ok=1; 1 → WAIT_REL with ack_ok=0.
  - WAIT_REL: when filtered clock = 1 and `ps2d_in` = 1, go → IDLE and pulse `tx_done_tick` (ack_ok=1) or `tx_err_tick` (ack_ok=0).
- Timeout: in START, DATA, STOP, ACK or WAIT_REL, if the cycle counter reaches TIMEOUT_CYCLES without `fall` (or without release in WAIT_REL), release both lines, pulse `tx_err_tick`, and go → IDLE.
- `wr_ps2` while not IDLE is ignored; `din` is not re-sampled.
- Reset (any state, including mid-frame): state = IDLE, `ps2c_oe`=0, `ps2d_oe`=0, `tx_idle`=1, `tx_done_tick`=0, `tx_err_tick`=0, filter = all ones, counters = 0. Both lines are released immediately (asynchronously).

## Timing
- `wr_ps2` high at cycle N in IDLE → `ps2c_oe`=1 and `tx_idle`=0 from cycle N+1.
- `ps2c_oe` is high for exactly INHIBIT_CYCLES+16 cycles. `ps2d_oe` rises INHIBIT_CYCLES cycles after `ps2c_oe` rises, and is high for 16 cycles before `ps2c_oe` falls.
- The data output changes on the clk cycle after `fall` is detected. `fall` itself lags a clean pad edge by 8–9 clk cycles, which is well inside the device's ≥5 µs low phase.
- All outputs are registered.
- `tx_done_tick` and `tx_err_tick` are never high together. Each pulses exactly once per accepted request, in the same cycle `tx_idle` returns to 1.
- A new `wr_ps2` is accepted the cycle `tx_idle`=1, including the cycle immediately after a done or error pulse.

## Test plan
- Send 0xED with a device model that ACKs (clock period 80 µs, data sampled on rising edges). Required: the device decodes start=0, bits 1,0,1,1,0,1,1,1 (LSB first), parity=1, stop=1; `tx_done_tick` pulses once; `tx_err_tick` stays 0.
- Send 0x00: required parity bit = 1. Send 0x01: required parity bit = 0. Verify `ps2c_oe` is high for exactly INHIBIT_CYCLES+16 cycles, and `ps2d_oe` is low until the last 16 of them.
- Device NACKs (data left high on the 11th clock) for 0xFF → `tx_err_tick` pulses once; `tx_done_tick` stays 0; both `oe` outputs are 0.
- Device stops clocking after bit 3 → `tx_err_tick` pulses exactly TIMEOUT_CYCLES cycles after the last `fall`; lines are released; a following `wr_ps2` with 0xF4 succeeds.
- `wr_ps2` with 0xAA pulsed during DATA of a 0x55 frame → only 0x55 is transmitted, with a single done pulse.
- Assert `reset` during DATA → `ps2c_oe`=0, `ps2d_oe`=0 and `tx_idle`=1 without waiting for a clk edge. After reset is released, a 0xED send completes normally.
- Inject 3-cycle glitches on `ps2c_in` during DATA → no extra bit advance; the frame is received correctly.
